// File: rtl/led_pattern_arbiter_if.sv
// ============================================================================
// Module      : led_pattern_arbiter_if
// Description : Requester-side bundle for the LED pattern arbiter: request
//               levels, pattern words, grant/done/busy status and pin drives.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_pattern_arbiter_if #(
    parameter int N_REQ        = 4,
    parameter int PATTERN_BITS = 8
);
    logic [N_REQ-1:0]              REQ;
    logic [N_REQ*PATTERN_BITS-1:0] PATTERN;
    logic [N_REQ-1:0]              GRANT;
    logic [N_REQ-1:0]              DONE;
    logic                          BUSY;
    logic                          LED;
    logic                          USBPU;

    modport master (
        output REQ, PATTERN,
        input  GRANT, DONE, BUSY, LED, USBPU
    );

    modport slave (
        input  REQ, PATTERN,
        output GRANT, DONE, BUSY, LED, USBPU
    );
endinterface

`default_nettype wire

// File: rtl/led_pattern_arbiter.sv
// ============================================================================
// Module      : led_pattern_arbiter
// Description : Round-robin, non-preemptive owner of the single board LED;
//               plays the granted pattern one bit per tick, then a dark gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_arbiter #(
    parameter int N_REQ        = 4,
    parameter int PATTERN_BITS = 8,
    parameter int TICK_DIV     = 1600000,
    parameter int GAP_TICKS    = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    led_pattern_arbiter_if.slave  bus
);

    localparam int PSW = $clog2(TICK_DIV);
    localparam int BIW = (PATTERN_BITS > 1) ? $clog2(PATTERN_BITS) : 1;
    localparam int GCW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int PTW = $clog2(N_REQ);

    localparam logic [PSW-1:0] TICK_LAST = PSW'(TICK_DIV - 1);
    localparam logic [BIW-1:0] BIT_LAST  = BIW'(PATTERN_BITS - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                  state_q,   state_d;
    logic [PSW-1:0]          presc_q,   presc_d;
    logic [BIW-1:0]          bit_idx_q, bit_idx_d;
    logic [GCW-1:0]          gap_cnt_q, gap_cnt_d;
    logic [PTW-1:0]          rr_ptr_q,  rr_ptr_d;
    logic [PATTERN_BITS-1:0] pat_q,     pat_d;
    logic [N_REQ-1:0]        grant_q,   grant_d;
    logic [N_REQ-1:0]        done_q,    done_d;
    logic                    busy_q,    busy_d;
    logic                    led_q,     led_d;

    logic                    w_tick;
    logic                    w_found;
    logic [PTW-1:0]          w_sel;
    logic [PTW-1:0]          w_cand;
    int                      w_sum;
    logic [PATTERN_BITS-1:0] w_pat_sel;
    logic [PATTERN_BITS-1:0] w_pat_shift;

    assign w_tick      = (presc_q == TICK_LAST);
    assign w_pat_sel   = PATTERN_BITS'(bus.PATTERN >> (w_sel * PATTERN_BITS));
    assign w_pat_shift = pat_q >> 1;

    // Scan starts just after the last owner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = 0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_sum = int'(rr_ptr_q) + k;
            if (w_sum >= N_REQ) begin
                w_sum = w_sum - N_REQ;
            end
            w_cand = PTW'(w_sum);
            if (!w_found && bus.REQ[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = w_tick ? '0 : presc_q + 1'b1;
        bit_idx_d = bit_idx_q;
        gap_cnt_d = gap_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        pat_d     = pat_q;
        grant_d   = grant_q;
        done_d    = '0;
        busy_d    = busy_q;
        led_d     = led_q;

        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                led_d   = 1'b0;
                if (w_found) begin
                    state_d   = S_PLAY;
                    presc_d   = '0;
                    bit_idx_d = '0;
                    rr_ptr_d  = w_sel;
                    pat_d     = w_pat_sel;
                    grant_d   = N_REQ'(1) << w_sel;
                    busy_d    = 1'b1;
                    led_d     = w_pat_sel[0];
                end
            end
            S_PLAY: begin
                if (w_tick) begin
                    if (bit_idx_q == BIT_LAST) begin
                        done_d    = grant_q;
                        grant_d   = '0;
                        led_d     = 1'b0;
                        gap_cnt_d = '0;
                        if (GAP_TICKS > 0) begin
                            state_d = S_GAP;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        pat_d     = w_pat_shift;
                        led_d     = w_pat_shift[0];
                    end
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            bit_idx_q <= '0;
            gap_cnt_q <= '0;
            rr_ptr_q  <= PTW'(N_REQ - 1);
            pat_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            bit_idx_q <= bit_idx_d;
            gap_cnt_q <= gap_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            pat_q     <= pat_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            led_q     <= led_d;
        end
    end

    assign bus.GRANT = grant_q;
    assign bus.DONE  = done_q;
    assign bus.BUSY  = busy_q;
    assign bus.LED   = led_q;
    assign bus.USBPU = 1'b0;

endmodule

`default_nettype wire
